// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/sub pipeline with valid/ready flow control
// Ports: clk, rst (async, active-high); in_valid/in_ready + A, B, Cin, sub operands;
//        out_valid/out_ready + Sum, Cout (sub: 1 = no borrow), Ovf (signed overflow).
module pipelined_adder #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);
   localparam int CHUNK = WIDTH / STAGES;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [STAGES-1:0] c_q, c_d, v_q, v_d, ci;
   logic              adv;
   assign adv       = ~v_q[STAGES-1] | out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign Sum       = s_q[STAGES-1];
   assign Cout      = c_q[STAGES-1];
   // b_q holds the effective (possibly inverted) operand, so a^b^s at the MSB is the carry into it
   assign Ovf       = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ s_q[STAGES-1][WIDTH-1] ^ c_q[STAGES-1];
   always_comb begin
      a_d[0] = A;
      b_d[0] = sub ? ~B : B;
      s_d[0] = '0;
      v_d[0] = in_valid;
      ci[0]  = Cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         s_d[k] = s_q[k-1];
         v_d[k] = v_q[k-1];
         ci[k]  = c_q[k-1];
      end
      for (int k = 0; k < STAGES; k++)
         {c_d[k], s_d[k][k*CHUNK +: CHUNK]} = {1'b0, a_d[k][k*CHUNK +: CHUNK]}
                                            + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
                                            + {{CHUNK{1'b0}}, ci[k]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         v_q <= v_d;
         c_q <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end
endmodule
